uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
- Synthesizable serial UART receiver, LSB-first, 8 data bits, optional parity, 1 stop bit (8N1 by default).
- Receives the SoC's uart_tx line (PULPino top level, clk = 25 MHz, 3.125 Mbaud in the standard bench).
- Delivers each received byte with a one-cycle word_done strobe and error flags.
- Intended consumers: a console/log capture block or a loop-back checker.

Parameters:
- CLK_FREQ_HZ, 25000000, system clock frequency in Hz.
- BAUD_RATE, 3125000, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division). Elaboration error if CLKS_PER_BIT < 4.
- PARITY_EN, 0, 1 = expect an even-parity bit between the data bits and the stop bit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; idle high; asynchronous to clk.
- rx_en  in  1  receive enable.
- rx_data  out  8  last received byte; holds until the next word_done.
- word_done  out  1  one-cycle strobe: frame complete, rx_data valid.
- parity_err  out  1  parity mismatch on the frame just completed; valid with word_done.
- frame_err  out  1  stop bit sampled low; valid with word_done.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - rx_data = 0x00; word_done, parity_err, frame_err, busy = 0.
  - State IDLE; both synchronizer flops and the previous-sample register = 1.
- Input synchronization: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- Counters: baud counter 0..CLKS_PER_BIT-1; bit index 0..7.
- IDLE:
  - Exit when rx_en = 1 and rx_s falls 1→0 → START, counter cleared.
  - A line already low when rx_en rises does not start a frame; a high level must be seen first.
- START:
  - At count (CLKS_PER_BIT-1)/2 (mid start bit), check rx_s.
  - rx_s = 1 → glitch: return to IDLE, no strobe.
  - rx_s = 0 → DATA, counter cleared.
- DATA:
  - Every CLKS_PER_BIT cycles (mid-bit), shift rx_s into bit[index], LSB first.
  - After index 7 → PARITY if PARITY_EN, else STOP.
- PARITY: one mid-bit sample. parity_err = (XOR of the 8 data bits) != sampled bit (even parity).
- STOP:
  - One mid-bit sample. frame_err = ~rx_s.
  - On the following cycle: word_done = 1 for exactly one cycle, rx_data updated, error flags updated; then → IDLE.
  - Latency: word_done rises 1 clk after the mid-stop-bit sample, i.e. ~(9.5 + PARITY_EN)·CLKS_PER_BIT + 3 clks after the start edge on rx (2 of those are synchronizer delay).
- Error flags change only together with word_done; they hold until the next strobe. parity_err is 0 when PARITY_EN = 0.
- A frame with frame_err is still delivered (word_done = 1, data as sampled).
- After any frame, IDLE needs rx_s = 1 before the next falling edge is accepted. A break (line held low) produces exactly one frame_err word, not repeated frames.
- rx_en deasserted mid-frame: abort to IDLE on the next clk; no word_done; rx_data and flags unchanged.
- Async reset mid-frame: immediately returns to reset values; no strobe.
- A back-to-back start bit immediately after the stop-bit sample (zero idle) must be received correctly: the falling edge is detected in IDLE on the cycle after word_done.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - function clks_per_bit(clk_hz, baud);
  - constant DATA_BITS = 8.
- Optional sub-module: sync_2ff (generic 2-flop synchronizer with reset value parameter), instantiated once for rx.
- Everything else is a single FSM plus datapath in uart_rx_8n1.

Test Plan (clk 40 ns, CLKS_PER_BIT = 8, 320 ns per bit):
1. Send 0x55 as 8N1 → one word_done pulse, rx_data = 0x55, parity_err = 0, frame_err = 0, busy low afterwards.
2. Send "Hi\n" (0x48, 0x69, 0x0A) back-to-back with zero idle → three strobes in order, data exact, no errors.
3. Start-bit glitch: rx low for 2 clks then high → no word_done, state back to IDLE, busy falls within 8 clks.
4. Send 0xA3 with the stop bit driven 0, then hold rx low 20 bit times → exactly one word_done with frame_err = 1, rx_data = 0xA3, no further strobes until rx returns high and a new frame is sent.
5. PARITY_EN = 1: send 0x07 with parity bit 1 → parity_err = 0; resend with parity bit 0 → parity_err = 1, rx_data = 0x07.
6. Drop rx_en during data bit 4 of 0xFF, or assert rst mid-frame → no word_done, rx_data keeps its previous value (0x00 after reset); the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   state_t      - receiver FSM states
//   DATA_BITS    - number of data bits in a character
//   clks_per_bit - clock cycles per bit for a given clock frequency and baud rate
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Integer division on purpose: the receiver resamples at the middle of
  // every bit, so a small rate error is absorbed within one frame.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset; both flops load RESET_VAL
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages reset to the same value so that no spurious edge appears
  // on q when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: UART receiver with LSB-first data, 8 data bits, optional even
// parity and 1 stop bit.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   rx         - serial line, idle high, asynchronous to clk
//   rx_en      - receive enable; dropping it mid-frame aborts the frame
//   rx_data    - last received byte, held until the next word_done
//   word_done  - one-cycle strobe when a frame completes
//   parity_err - parity mismatch on the completed frame (valid with word_done)
//   frame_err  - stop bit sampled low on the completed frame (valid with word_done)
//   busy       - high whenever the receiver is not idle
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 3125000,
  parameter int PARITY_EN   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 word_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CPB - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  // Fewer than four clocks per bit leaves no room for the synchronizer
  // delay plus a meaningful mid-bit sample point.
  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx_8n1: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
  end

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 par_bit;
  logic                 stop_bit;
  logic                 stop_seen;

  // Idle-high reset value keeps a reset release from looking like a start edge.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign busy = (state != IDLE);

  // Receiver FSM and datapath. rx_prev tracks rx_s in every state, so a
  // line that is already low (break, or rx_en rising while low) never
  // produces a falling edge in IDLE; a high level must be seen first.
  // The stop bit is sampled first and the word is delivered on the
  // following cycle, then the FSM drops straight back to IDLE so a
  // zero-idle next start bit is still caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_prev    <= 1'b1;
      par_bit    <= 1'b0;
      stop_bit   <= 1'b1;
      stop_seen  <= 1'b0;
      rx_data    <= '0;
      word_done  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_prev   <= rx_s;
      word_done <= 1'b0;

      if ((state != IDLE) && !rx_en) begin
        state     <= IDLE;
        stop_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_en && rx_prev && !rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end

          START: begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == CNT_LAST) begin
              cnt            <= '0;
              shreg[bit_idx] <= rx_s;
              if (bit_idx == IDX_LAST) begin
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          PARITY: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STOP: begin
            if (stop_seen) begin
              stop_seen  <= 1'b0;
              word_done  <= 1'b1;
              rx_data    <= shreg;
              frame_err  <= ~stop_bit;
              parity_err <= (PARITY_EN != 0) && ((^shreg) != par_bit);
              state      <= IDLE;
            end else if (cnt == CNT_LAST) begin
              stop_bit  <= rx_s;
              stop_seen <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed plus randomized bench for uart_rx_8n1.
// Two receivers share clock, reset and rx_en: dut0 without parity, dut1 with
// even parity. Each received word is recorded by a monitor and compared
// against words predicted from the frames the bench puts on the line.
module tb_uart_rx_8n1;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rx_en;
  logic       rx0;
  logic       rx1;
  logic [7:0] rx_data0;
  logic [7:0] rx_data1;
  logic       word_done0;
  logic       word_done1;
  logic       parity_err0;
  logic       parity_err1;
  logic       frame_err0;
  logic       frame_err1;
  logic       busy0;
  logic       busy1;

  int checks = 0;
  int errors = 0;

  // Words are packed as {data[7:0], parity_err, frame_err}.
  logic [9:0] exp_q0[$];
  logic [9:0] got_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] got_q1[$];

  uart_rx_8n1 #(
    .CLK_FREQ_HZ(25000000),
    .BAUD_RATE  (3125000),
    .PARITY_EN  (0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx0),
    .rx_en     (rx_en),
    .rx_data   (rx_data0),
    .word_done (word_done0),
    .parity_err(parity_err0),
    .frame_err (frame_err0),
    .busy      (busy0)
  );

  uart_rx_8n1 #(
    .CLK_FREQ_HZ(25000000),
    .BAUD_RATE  (3125000),
    .PARITY_EN  (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx1),
    .rx_en     (rx_en),
    .rx_data   (rx_data1),
    .word_done (word_done1),
    .parity_err(parity_err1),
    .frame_err (frame_err1),
    .busy      (busy1)
  );

  // 25 MHz system clock.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Record every delivered word, sampling away from the active edge.
  always @(negedge clk) begin
    if (word_done0) got_q0.push_back({rx_data0, parity_err0, frame_err0});
    if (word_done1) got_q1.push_back({rx_data1, parity_err1, frame_err1});
  end

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold one line level for one bit time.
  task automatic driveBit(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Put one frame on the selected line and predict the word it should yield.
  // Parity is only sent to dut1; the predicted parity flag follows the
  // even-parity rule, the frame flag is simply the inverse of the stop bit.
  task automatic applyStimulus(input int sel, input logic [7:0] data,
                               input logic par_val, input logic stop_val,
                               input int gap_bits);
    logic perr;
    perr = (sel == 1) ? ((^data) != par_val) : 1'b0;
    if (sel == 0) exp_q0.push_back({data, perr, ~stop_val});
    else exp_q1.push_back({data, perr, ~stop_val});
    driveBit(sel, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(sel, data[i]);
    if (sel == 1) driveBit(sel, par_val);
    driveBit(sel, stop_val);
    for (int i = 0; i < gap_bits; i++) driveBit(sel, 1'b1);
  endtask

  // Compare the words seen so far against the prediction, then start afresh.
  task automatic compareWords(input string tag, input int sel);
    logic [9:0] eq[$];
    logic [9:0] gq[$];
    if (sel == 0) begin
      eq = exp_q0;
      gq = got_q0;
      exp_q0.delete();
      got_q0.delete();
    end else begin
      eq = exp_q1;
      gq = got_q1;
      exp_q1.delete();
      got_q1.delete();
    end
    checkOutput({tag, " word count"}, gq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < gq.size(); i++)
      checkOutput($sformatf("%s word%0d", tag, i), gq[i], eq[i]);
  endtask

  // Linear sequence of directed steps followed by randomized frames.
  initial begin
    logic       seen_busy;
    logic [7:0] d;
    logic       p;
    logic       s;
    int         gap;

    rst   = 1'b1;
    rx_en = 1'b1;
    rx0   = 1'b1;
    rx1   = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("reset dut0 outputs", {rx_data0, word_done0, parity_err0, frame_err0, busy0}, 12'h000);
    checkOutput("reset dut1 outputs", {rx_data1, word_done1, parity_err1, frame_err1, busy1}, 12'h000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single frame 0x55");
    applyStimulus(0, 8'h55, 1'b0, 1'b1, 2);
    compareWords("frame 0x55", 0);
    checkOutput("0x55 busy after", busy0, 1'b0);
    checkOutput("0x55 rx_data held", rx_data0, 8'h55);

    $display("[TB] back-to-back Hi\\n");
    applyStimulus(0, 8'h48, 1'b0, 1'b1, 0);
    applyStimulus(0, 8'h69, 1'b0, 1'b1, 0);
    applyStimulus(0, 8'h0A, 1'b0, 1'b1, 2);
    compareWords("Hi newline", 0);

    $display("[TB] start-bit glitch");
    rx0 = 1'b0;
    repeat (2) @(negedge clk);
    rx0 = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy0) seen_busy = 1'b1;
    end
    checkOutput("glitch busy seen", seen_busy, 1'b1);
    checkOutput("glitch busy end", busy0, 1'b0);
    compareWords("glitch", 0);

    $display("[TB] frame error followed by break");
    applyStimulus(0, 8'hA3, 1'b0, 1'b0, 0);
    repeat (20 * CPB) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    compareWords("break", 0);
    applyStimulus(0, 8'h5A, 1'b0, 1'b1, 2);
    compareWords("after break", 0);

    $display("[TB] even parity");
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1);
    applyStimulus(1, 8'h07, 1'b0, 1'b1, 2);
    compareWords("parity 0x07", 1);
    checkOutput("parity rx_data", rx_data1, 8'h07);

    $display("[TB] rx_en dropped during data bit 4 of 0xFF");
    rx0 = 1'b0;
    repeat (CPB) @(negedge clk);
    rx0 = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    checkOutput("abort busy before", busy0, 1'b1);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort busy after", busy0, 1'b0);
    rx_en = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    compareWords("rx_en abort", 0);
    checkOutput("abort rx_data kept", rx_data0, 8'h5A);
    applyStimulus(0, 8'h3C, 1'b0, 1'b1, 2);
    compareWords("after abort", 0);

    $display("[TB] reset mid-frame");
    rx0 = 1'b0;
    repeat (CPB) @(negedge clk);
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset busy", busy0, 1'b0);
    checkOutput("mid reset rx_data", rx_data0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    compareWords("mid reset", 0);
    checkOutput("mid reset rx_data after", rx_data0, 8'h00);
    applyStimulus(0, 8'h3C, 1'b0, 1'b1, 2);
    compareWords("after reset", 0);

    $display("[TB] random frames without parity");
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(255));
      s   = ($urandom_range(3) != 0);
      gap = $urandom_range(2);
      if (!s && gap == 0) gap = 1;
      applyStimulus(0, d, 1'b0, s, gap);
    end
    repeat (3 * CPB) @(negedge clk);
    compareWords("random 8N1", 0);

    $display("[TB] random frames with parity");
    for (int n = 0; n < 8; n++) begin
      d   = 8'($urandom_range(255));
      p   = 1'($urandom_range(1));
      gap = $urandom_range(1);
      applyStimulus(1, d, p, 1'b1, gap);
    end
    repeat (3 * CPB) @(negedge clk);
    compareWords("random 8E1", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
